// File: rtl/mem_access_ctrl.sv
// Single-outstanding initiator for the memory_unit bus: valid/ready request in, one bus access, valid/ready response out.
// Optional build macro WRITE_VERIFY_EN adds a read-back of every write and reports mismatches on rsp_err.
module mem_access_ctrl #(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_select,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    VERIFY = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic              write_q, write_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [2:0]        cnt_q, cnt_nx;
`ifdef WRITE_VERIFY_EN
  logic [DATA_W-1:0] wdata_q, wdata_nx;
`endif

  logic              req_ready_nx;
  logic              rsp_valid_nx;
  logic              rsp_write_nx;
  logic [DATA_W-1:0] rsp_rdata_nx;
  logic              rsp_err_nx;
  logic              mem_select_nx;
  logic              mem_op_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_data_in_nx;

  // Every output is a flop; the comb block computes next-cycle output values
  // alongside the next state so that bus strobes line up with the state.
  always_comb begin
    state_nx       = state;
    write_nx       = write_q;
    addr_nx        = addr_q;
    cnt_nx         = cnt_q;
`ifdef WRITE_VERIFY_EN
    wdata_nx       = wdata_q;
`endif
    req_ready_nx   = 1'b0;
    rsp_valid_nx   = rsp_valid;
    rsp_write_nx   = rsp_write;
    rsp_rdata_nx   = rsp_rdata;
    rsp_err_nx     = rsp_err;
    mem_select_nx  = 1'b0;
    mem_op_nx      = 1'b0;
    mem_addr_nx    = '0;
    mem_data_in_nx = '0;

    case (state)
      IDLE: begin
        req_ready_nx = 1'b1;
        if (req_valid && req_ready) begin
          state_nx       = ACCESS;
          req_ready_nx   = 1'b0;
          write_nx       = req_write;
          addr_nx        = req_addr;
`ifdef WRITE_VERIFY_EN
          wdata_nx       = req_write ? req_wdata : '0;
`endif
          mem_select_nx  = 1'b1;
          mem_op_nx      = req_write;
          mem_addr_nx    = req_addr;
          mem_data_in_nx = req_write ? req_wdata : '0;
        end
      end

      ACCESS: begin
        if (write_q) begin
`ifdef WRITE_VERIFY_EN
          state_nx      = VERIFY;
          mem_select_nx = 1'b1;
          mem_addr_nx   = addr_q;
`else
          state_nx      = RESP;
          rsp_valid_nx  = 1'b1;
          rsp_write_nx  = 1'b1;
          rsp_rdata_nx  = '0;
          rsp_err_nx    = 1'b0;
`endif
        end else begin
          state_nx = WAIT;
          cnt_nx   = 3'(READ_LATENCY);
        end
      end

      VERIFY: begin
        state_nx = WAIT;
        cnt_nx   = 3'(READ_LATENCY);
      end

      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_write_nx = write_q;
          rsp_rdata_nx = mem_data_out;
`ifdef WRITE_VERIFY_EN
          rsp_err_nx   = write_q && (mem_data_out != wdata_q);
`else
          rsp_err_nx   = 1'b0;
`endif
        end else begin
          cnt_nx = cnt_q - 3'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          req_ready_nx = 1'b1;
          rsp_valid_nx = 1'b0;
          rsp_write_nx = 1'b0;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b0;
        end
      end

      default: begin
        state_nx     = IDLE;
        req_ready_nx = 1'b1;
        rsp_valid_nx = 1'b0;
        rsp_write_nx = 1'b0;
        rsp_rdata_nx = '0;
        rsp_err_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
`ifdef WRITE_VERIFY_EN
      wdata_q     <= '0;
`endif
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      mem_select  <= 1'b0;
      mem_op      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      state       <= state_nx;
      write_q     <= write_nx;
      addr_q      <= addr_nx;
      cnt_q       <= cnt_nx;
`ifdef WRITE_VERIFY_EN
      wdata_q     <= wdata_nx;
`endif
      req_ready   <= req_ready_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_write   <= rsp_write_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_err     <= rsp_err_nx;
      mem_select  <= mem_select_nx;
      mem_op      <= mem_op_nx;
      mem_addr    <= mem_addr_nx;
      mem_data_in <= mem_data_in_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: memory_unit emulation on the bus, expectations from a plain array model.
// With WRITE_VERIFY_EN defined the emulated memory has data bit 0 stuck at 0.
module tb_mem_access_ctrl;
  localparam int RL = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_select, mem_op;
  logic [2:0] mem_addr;
  logic [7:0] mem_data_in, mem_data_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  logic [7:0] mem_arr [8];
  logic [7:0] rd_pipe [RL];
  logic [7:0] ref_mem [8];

  mem_access_ctrl #(.ADDR_W(3), .DATA_W(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_select(mem_select), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory_unit emulation: write on the access edge, read data RL edges later
  always @(posedge clk) begin
    if (mem_select && mem_op)
`ifdef WRITE_VERIFY_EN
      mem_arr[mem_addr] <= mem_data_in & 8'hFE;
`else
      mem_arr[mem_addr] <= mem_data_in;
`endif
    rd_pipe[0] <= mem_arr[mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[RL-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request, called and returning at a negedge. acc = cycle count at accept.
  task automatic do_req(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input int unsigned stall, input logic hold, output int unsigned acc);
    logic [7:0] stored, exp_rd;
    logic       exp_err, hs, seen;
    int unsigned exp_lat, exp_sel, k, sel_cnt;
`ifdef WRITE_VERIFY_EN
    stored = d & 8'hFE;
`else
    stored = d;
`endif
    if (wr) begin
      ref_mem[a] = stored;
`ifdef WRITE_VERIFY_EN
      exp_rd = stored; exp_err = (stored != d); exp_lat = 2 + RL; exp_sel = 2;
`else
      exp_rd = 8'h00;  exp_err = 1'b0;          exp_lat = 1;      exp_sel = 1;
`endif
    end else begin
      exp_rd = ref_mem[a]; exp_err = 1'b0; exp_lat = 1 + RL; exp_sel = 1;
    end

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    rsp_ready = (stall == 0);
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = req_ready;
      @(posedge clk);
      if (!hs) @(negedge clk);
    end
    check_eq("accept", hs, 1'b1);
    @(negedge clk);
    acc = cyc;
    if (!hold) begin
      req_valid = 1'b0; req_write = 1'bx; req_addr = 'x; req_wdata = 'x;
    end
    if (!hs) return;

    check_eq("bus_select", mem_select, 1'b1);
    check_eq("bus_op", mem_op, wr);
    check_eq("bus_addr", mem_addr, a);
    check_eq("bus_wdata", mem_data_in, wr ? d : 8'h00);
    check_eq("busy_ready", req_ready, 1'b0);

    sel_cnt = 1; k = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (mem_select) sel_cnt++;
      seen = rsp_valid;
    end
    check_eq("rsp_seen", seen, 1'b1);
    check_eq("rsp_latency", k, exp_lat);
    check_eq("select_pulses", sel_cnt, exp_sel);
    check_eq("rsp_write", rsp_write, wr);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_err", rsp_err, exp_err);

    for (int s = 0; s < int'(stall); s++) begin
      @(posedge clk); @(negedge clk);
      check_eq("stall_valid", rsp_valid, 1'b1);
      check_eq("stall_rdata", rsp_rdata, exp_rd);
      check_eq("stall_err", rsp_err, exp_err);
      check_eq("stall_ready", req_ready, 1'b0);
      check_eq("stall_select", mem_select, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("retire_valid", rsp_valid, 1'b0);
    check_eq("retire_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned acc, acc_prev, wr_gap, rd_gap;
    logic seen;
    for (int i = 0; i < 8; i++) begin mem_arr[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int i = 0; i < RL; i++) rd_pipe[i] = 8'h00;
`ifdef WRITE_VERIFY_EN
    wr_gap = 4 + RL;
`else
    wr_gap = 3;
`endif
    rd_gap = 3 + RL;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #22;
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_outs", {rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_select, mem_op, mem_addr, mem_data_in}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // reset while a read is waiting on memory latency
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_eq("midrst_ready", req_ready, 1'b1);
    check_eq("midrst_outs", {rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_select, mem_op, mem_addr, mem_data_in}, '0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); @(negedge clk); if (rsp_valid) seen = 1'b1; end
    check_eq("midrst_no_rsp", seen, 1'b0);

    do_req(1'b1, 3'd1, 8'h49, 0, 1'b0, acc);
    do_req(1'b0, 3'd1, 8'h00, 0, 1'b0, acc);
    do_req(1'b1, 3'd0, 8'hCC, 0, 1'b0, acc);
    do_req(1'b1, 3'd7, 8'h33, 0, 1'b0, acc);
    do_req(1'b0, 3'd0, 8'h00, 0, 1'b0, acc);
    do_req(1'b0, 3'd7, 8'h00, 0, 1'b0, acc);
    do_req(1'b0, 3'd0, 8'h00, 5, 1'b1, acc);
    do_req(1'b1, 3'd3, 8'h01, 0, 1'b0, acc);

    // back-to-back with req_valid held high
    do_req(1'b1, 3'd4, 8'hA5, 0, 1'b1, acc_prev);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 3'(5 + i), 8'(8'h10 + i), 0, 1'b1, acc);
      check_eq("wr_spacing", acc - acc_prev, wr_gap);
      acc_prev = acc;
    end
    do_req(1'b0, 3'd5, 8'h00, 0, 1'b1, acc_prev);
    do_req(1'b0, 3'd6, 8'h00, 0, 1'b1, acc);
    check_eq("rd_spacing", acc - acc_prev, rd_gap);

    for (int n = 0; n < 40; n++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), acc);
    req_valid = 1'b0;
    for (int a = 0; a < 8; a++) do_req(1'b0, 3'(a), 8'h00, 0, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
